// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - opcodes, REGIMM rt codes and FSM states for the branch resolve unit
package branch_pkg;

  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;

  localparam logic [4:0] RT_BLTZ = 5'd0;
  localparam logic [4:0] RT_BGEZ = 5'd1;

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    REDIRECT
  } br_state_t;

  // True for every opcode this unit resolves; all others are accepted and dropped
  function automatic logic is_branch(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_REGIMM) ||
           (op == OP_BGTZ) || (op == OP_BLEZ);
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// rtl/branch_cond_eval.sv - combinational branch condition evaluation
module branch_cond_eval (
  input  logic [5:0]  opcode,
  input  logic [4:0]  rt,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        taken
);
  import branch_pkg::*;

  // Pick the signed comparison implied by the opcode; REGIMM also decodes rt
  always_comb begin
    taken = 1'b0;
    case (opcode)
      OP_BEQ:    taken = (rs_val == rt_val);
      OP_BNE:    taken = (rs_val != rt_val);
      OP_REGIMM: begin
        if (rt == RT_BGEZ)      taken = ~rs_val[31];
        else if (rt == RT_BLTZ) taken = rs_val[31];
        else                    taken = 1'b0;
      end
      OP_BGTZ:   taken = ($signed(rs_val) > 32'sd0);
      OP_BLEZ:   taken = ($signed(rs_val) <= 32'sd0);
      default:   taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - execute-stage branch resolution, fetch redirect and statistics
module branch_resolve_unit #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [5:0]        id_opcode,
  input  logic [4:0]        id_rt,
  input  logic [ADDR_W-1:0] id_pc,
  input  logic [15:0]       id_imm,
  input  logic [31:0]       id_rs_val,
  input  logic [31:0]       id_rt_val,
  input  logic              flush_in,
  output logic              resolved_valid,
  output logic              resolved_taken,
  output logic              redirect_valid,
  input  logic              redirect_ready,
  output logic [ADDR_W-1:0] redirect_target,
  output logic              flush_out,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  taken_cnt
);
  import branch_pkg::*;

  br_state_t         state;
  logic [5:0]        cap_opcode;
  logic [4:0]        cap_rt;
  logic [ADDR_W-1:0] cap_pc;
  logic [15:0]       cap_imm;
  logic [31:0]       cap_rs_val;
  logic [31:0]       cap_rt_val;
  logic [ADDR_W-1:0] target_r;
  logic [ADDR_W-1:0] imm_ext;
  logic [ADDR_W-1:0] target_next;
  logic              taken;
  logic              accept;
  logic              resolve;

  branch_cond_eval u_cond (
    .opcode (cap_opcode),
    .rt     (cap_rt),
    .rs_val (cap_rs_val),
    .rt_val (cap_rt_val),
    .taken  (taken)
  );

  // A flush in the same cycle as a decode handshake means the instruction is wrong-path
  assign accept  = (state == IDLE) && id_valid && !flush_in && is_branch(id_opcode);
  assign resolve = (state == EVAL) && !flush_in;

  // Word offset, sign-extended then scaled; overflow wraps silently
  assign imm_ext     = ADDR_W'($signed(cap_imm));
  assign target_next = cap_pc + ADDR_W'(4) + (imm_ext << 2);

  assign id_ready        = (state == IDLE);
  assign resolved_valid  = resolve;
  assign resolved_taken  = resolve && taken;
  assign redirect_valid  = (state == REDIRECT);
  assign redirect_target = target_r;
  assign flush_out       = (state == REDIRECT) && redirect_ready && !flush_in;

  // Control FSM: capture from decode, resolve for one cycle, hold redirect until fetch takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cap_opcode <= '0;
      cap_rt     <= '0;
      cap_pc     <= '0;
      cap_imm    <= '0;
      cap_rs_val <= '0;
      cap_rt_val <= '0;
      target_r   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cap_opcode <= id_opcode;
            cap_rt     <= id_rt;
            cap_pc     <= id_pc;
            cap_imm    <= id_imm;
            cap_rs_val <= id_rs_val;
            cap_rt_val <= id_rt_val;
            state      <= EVAL;
          end
        end
        EVAL: begin
          if (flush_in) begin
            state <= IDLE;
          end else if (taken) begin
            target_r <= target_next;
            state    <= REDIRECT;
          end else begin
            state <= IDLE;
          end
        end
        REDIRECT: begin
          if (flush_in || redirect_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Saturating performance counters, advanced only by unflushed resolutions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt <= '0;
      taken_cnt  <= '0;
    end else if (resolve) begin
      if (!(&branch_cnt))          branch_cnt <= branch_cnt + CNT_W'(1);
      if (taken && !(&taken_cnt))  taken_cnt  <= taken_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - self-checking bench for branch_resolve_unit
module tb_branch_resolve_unit;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [5:0]  id_opcode;
  logic [4:0]  id_rt;
  logic [31:0] id_pc;
  logic [15:0] id_imm;
  logic [31:0] id_rs_val;
  logic [31:0] id_rt_val;
  logic        flush_in;
  logic        redirect_ready;

  logic        id_ready, resolved_valid, resolved_taken, redirect_valid, flush_out;
  logic [31:0] redirect_target;
  logic [15:0] branch_cnt, taken_cnt;

  logic        sm_id_ready, sm_resolved_valid, sm_resolved_taken, sm_redirect_valid, sm_flush_out;
  logic [31:0] sm_redirect_target;
  logic [1:0]  sm_branch_cnt, sm_taken_cnt;

  branch_resolve_unit #(.ADDR_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
    .id_opcode(id_opcode), .id_rt(id_rt), .id_pc(id_pc), .id_imm(id_imm),
    .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .flush_in(flush_in),
    .resolved_valid(resolved_valid), .resolved_taken(resolved_taken),
    .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
    .redirect_target(redirect_target), .flush_out(flush_out),
    .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
  );

  branch_resolve_unit #(.ADDR_W(32), .CNT_W(2)) dut_sm (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(sm_id_ready),
    .id_opcode(id_opcode), .id_rt(id_rt), .id_pc(id_pc), .id_imm(id_imm),
    .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .flush_in(flush_in),
    .resolved_valid(sm_resolved_valid), .resolved_taken(sm_resolved_taken),
    .redirect_valid(sm_redirect_valid), .redirect_ready(redirect_ready),
    .redirect_target(sm_redirect_target), .flush_out(sm_flush_out),
    .branch_cnt(sm_branch_cnt), .taken_cnt(sm_taken_cnt)
  );

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rt;
    logic [31:0] pc;
    logic [15:0] imm;
    logic [31:0] rs;
    logic [31:0] rtv;
    logic        taken;
    logic [31:0] target;
  } vec_t;

  typedef struct {
    logic        taken;
    logic [31:0] target;
  } exp_t;

  localparam int NVEC = 14;
  vec_t        vecs [NVEC];
  exp_t        exp_q [$];
  logic [31:0] tgt_q [$];
  int          checks;
  int          failures;
  int          flush_pulses;
  bit          sb_en;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: pop expected outcome on each resolve, expected target on each redirect handshake
  always @(negedge clk) begin
    if (sb_en && rst_n) begin
      if (resolved_valid) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_resolve", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_taken", {31'd0, resolved_taken}, {31'd0, e.taken});
          if (e.taken) tgt_q.push_back(e.target);
        end
      end
      if (flush_out) begin
        flush_pulses++;
        if (tgt_q.size() == 0) chk("sb_unexpected_redirect", 32'd1, 32'd0);
        else                   chk("sb_target", redirect_target, tgt_q.pop_front());
      end
    end
  end

  task automatic drive(input vec_t v);
    id_valid  = 1'b1;
    id_opcode = v.op;
    id_rt     = v.rt;
    id_pc     = v.pc;
    id_imm    = v.imm;
    id_rs_val = v.rs;
    id_rt_val = v.rtv;
  endtask

  task automatic run_vec(input vec_t v, input int hold);
    exp_t e;
    drive(v);
    e.taken  = v.taken;
    e.target = v.target;
    exp_q.push_back(e);
    tick();
    id_valid = 1'b0;
    chk("lat_resolved_valid", {31'd0, resolved_valid}, 32'd1);
    chk("lat_id_ready_low", {31'd0, id_ready}, 32'd0);
    tick();
    if (v.taken) begin
      chk("redirect_valid", {31'd0, redirect_valid}, 32'd1);
      chk("redirect_target", redirect_target, v.target);
      for (int k = 0; k < hold; k++) begin
        tick();
        chk("hold_target", redirect_target, v.target);
        chk("hold_no_flush", {31'd0, flush_out}, 32'd0);
      end
      redirect_ready = 1'b1;
      #1;
      chk("flush_pulse", {31'd0, flush_out}, 32'd1);
      tick();
      redirect_ready = 1'b0;
      #1;
      chk("flush_once", {31'd0, flush_out}, 32'd0);
    end else begin
      chk("nt_no_redirect", {31'd0, redirect_valid}, 32'd0);
    end
    chk("back_idle", {31'd0, id_ready}, 32'd1);
  endtask

  initial begin
    int   n_taken;
    vec_t beq_t;
    checks       = 0;
    failures     = 0;
    flush_pulses = 0;
    sb_en        = 1'b0;
    n_taken      = 0;

    //          op     rt     pc            imm       rs            rt_val   taken target
    vecs[0]  = '{6'h04, 5'd0,  32'h0000_1000, 16'h0004, 32'd5,        32'd5,   1'b1, 32'h0000_1014};
    vecs[1]  = '{6'h05, 5'd0,  32'h0000_1100, 16'h0004, 32'd7,        32'd7,   1'b0, 32'h0};
    vecs[2]  = '{6'h01, 5'd0,  32'h0000_2000, 16'h0010, 32'hFFFF_FFFF, 32'd0,  1'b1, 32'h0000_2044};
    vecs[3]  = '{6'h01, 5'd1,  32'h0000_3000, 16'h0000, 32'd0,        32'd0,   1'b1, 32'h0000_3004};
    vecs[4]  = '{6'h07, 5'd0,  32'h0000_3100, 16'h0002, 32'd0,        32'd0,   1'b0, 32'h0};
    vecs[5]  = '{6'h06, 5'd0,  32'h0000_4000, 16'h0002, 32'h8000_0000, 32'd0,  1'b1, 32'h0000_400C};
    vecs[6]  = '{6'h01, 5'd16, 32'h0000_4100, 16'h0002, 32'd0,        32'd0,   1'b0, 32'h0};
    vecs[7]  = '{6'h04, 5'd0,  32'h0000_0010, 16'hFFF8, 32'd0,        32'd0,   1'b1, 32'hFFFF_FFF4};
    vecs[8]  = '{6'h04, 5'd0,  32'hFFFF_FFFC, 16'h0001, 32'd9,        32'd9,   1'b1, 32'h0000_0004};
    vecs[9]  = '{6'h07, 5'd0,  32'h0000_5000, 16'h0001, 32'd1,        32'd0,   1'b1, 32'h0000_5008};
    vecs[10] = '{6'h01, 5'd0,  32'h0000_5100, 16'h0001, 32'd0,        32'd0,   1'b0, 32'h0};
    vecs[11] = '{6'h06, 5'd0,  32'h0000_5200, 16'h0001, 32'd1,        32'd0,   1'b0, 32'h0};
    vecs[12] = '{6'h04, 5'd0,  32'h0000_5300, 16'h0001, 32'd1,        32'd2,   1'b0, 32'h0};
    vecs[13] = '{6'h05, 5'd0,  32'h0000_6000, 16'h7FFF, 32'd1,        32'd2,   1'b1, 32'h0002_6000};
    beq_t    = '{6'h04, 5'd0,  32'h0000_7000, 16'h0001, 32'd3,        32'd3,   1'b1, 32'h0000_7008};

    rst_n = 1'b0; id_valid = 1'b0; id_opcode = '0; id_rt = '0; id_pc = '0; id_imm = '0;
    id_rs_val = '0; id_rt_val = '0; flush_in = 1'b0; redirect_ready = 1'b0;
    repeat (2) tick();
    chk("rst_id_ready", {31'd0, id_ready}, 32'd1);
    chk("rst_resolved_valid", {31'd0, resolved_valid}, 32'd0);
    chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    chk("rst_redirect_target", redirect_target, 32'd0);
    chk("rst_flush_out", {31'd0, flush_out}, 32'd0);
    chk("rst_branch_cnt", {16'd0, branch_cnt}, 32'd0);
    chk("rst_taken_cnt", {16'd0, taken_cnt}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Non-branch opcode is consumed without leaving IDLE
    id_valid = 1'b1; id_opcode = 6'h00; id_rs_val = 32'd4; id_rt_val = 32'd4;
    tick();
    id_valid = 1'b0;
    chk("nonbr_id_ready", {31'd0, id_ready}, 32'd1);
    chk("nonbr_no_resolve", {31'd0, resolved_valid}, 32'd0);

    sb_en = 1'b1;
    for (int i = 0; i < NVEC; i++) begin
      run_vec(vecs[i], (i == 0) ? 3 : (i % 3));
      if (vecs[i].taken) n_taken++;
      chk("branch_cnt", {16'd0, branch_cnt}, i + 1);
      chk("taken_cnt", {16'd0, taken_cnt}, n_taken);
      chk("sat_branch_cnt", {30'd0, sm_branch_cnt}, (i + 1 > 3) ? 3 : i + 1);
      chk("sat_taken_cnt", {30'd0, sm_taken_cnt}, (n_taken > 3) ? 3 : n_taken);
    end
    tick();
    sb_en = 1'b0;
    chk("sb_exp_drained", exp_q.size(), 32'd0);
    chk("sb_tgt_drained", tgt_q.size(), 32'd0);
    chk("flush_pulse_count", flush_pulses, n_taken);

    // flush_in during EVAL: no resolve, counters untouched
    drive(beq_t);
    tick();
    id_valid = 1'b0; flush_in = 1'b1;
    #1;
    chk("evalflush_no_resolve", {31'd0, resolved_valid}, 32'd0);
    tick();
    flush_in = 1'b0;
    chk("evalflush_idle", {31'd0, id_ready}, 32'd1);
    chk("evalflush_no_redirect", {31'd0, redirect_valid}, 32'd0);
    chk("evalflush_branch_cnt", {16'd0, branch_cnt}, 32'd14);
    chk("evalflush_taken_cnt", {16'd0, taken_cnt}, 32'd8);

    // flush_in coincident with redirect_ready: flush wins, no flush_out
    drive(beq_t);
    tick();
    id_valid = 1'b0;
    tick();
    chk("rf_redirect_valid", {31'd0, redirect_valid}, 32'd1);
    flush_in = 1'b1; redirect_ready = 1'b1;
    #1;
    chk("rf_no_flush_out", {31'd0, flush_out}, 32'd0);
    tick();
    flush_in = 1'b0; redirect_ready = 1'b0;
    chk("rf_idle", {31'd0, id_ready}, 32'd1);
    chk("rf_redirect_dropped", {31'd0, redirect_valid}, 32'd0);
    chk("rf_branch_cnt", {16'd0, branch_cnt}, 32'd15);
    chk("rf_taken_cnt", {16'd0, taken_cnt}, 32'd9);

    // flush_in in IDLE blocks capture
    drive(beq_t);
    flush_in = 1'b1;
    tick();
    id_valid = 1'b0; flush_in = 1'b0;
    chk("idleflush_no_resolve", {31'd0, resolved_valid}, 32'd0);
    chk("idleflush_idle", {31'd0, id_ready}, 32'd1);
    tick();
    chk("idleflush_no_redirect", {31'd0, redirect_valid}, 32'd0);
    chk("sat_branch_final", {30'd0, sm_branch_cnt}, 32'd3);
    chk("sat_taken_final", {30'd0, sm_taken_cnt}, 32'd3);

    // Asynchronous reset while a redirect is pending
    drive(beq_t);
    tick();
    id_valid = 1'b0;
    tick();
    chk("ar_redirect_valid", {31'd0, redirect_valid}, 32'd1);
    redirect_ready = 1'b1; rst_n = 1'b0;
    #1;
    chk("ar_redirect_valid_low", {31'd0, redirect_valid}, 32'd0);
    chk("ar_target_zero", redirect_target, 32'd0);
    chk("ar_no_flush_out", {31'd0, flush_out}, 32'd0);
    chk("ar_branch_cnt", {16'd0, branch_cnt}, 32'd0);
    chk("ar_taken_cnt", {16'd0, taken_cnt}, 32'd0);
    chk("ar_sm_branch_cnt", {30'd0, sm_branch_cnt}, 32'd0);
    chk("ar_id_ready", {31'd0, id_ready}, 32'd1);
    redirect_ready = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Execute-stage counterpart to the decode-stage branch flag: accepts a branch from decode, evaluates its condition, computes the target, and issues a redirect to fetch through a valid/ready handshake.
- Stalls decode while a branch is being resolved or a redirect is pending.
- Keeps saturating resolved and taken branch counters for performance monitoring.

Parameters:
- ADDR_W, 32, width of PC and target addresses.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active low
- id_valid  in  1  decode presents an instruction
- id_ready  out  1  unit can accept from decode
- id_opcode  in  6  instruction opcode [31:26]
- id_rt  in  5  rt field; selects bgez/bltz under opcode 0x01
- id_pc  in  ADDR_W  PC of the branch instruction
- id_imm  in  16  branch offset in words
- id_rs_val  in  32  forwarded rs operand
- id_rt_val  in  32  forwarded rt operand
- flush_in  in  1  exception flush; cancels any in-flight branch
- resolved_valid  out  1  one-cycle pulse: branch resolved
- resolved_taken  out  1  outcome, qualified by resolved_valid
- redirect_valid  out  1  taken redirect pending
- redirect_ready  in  1  fetch accepts redirect
- redirect_target  out  ADDR_W  new fetch PC
- flush_out  out  1  one-cycle pulse on redirect handshake; kills wrong-path IF/ID
- branch_cnt  out  CNT_W  resolved branches, saturating
- taken_cnt  out  CNT_W  taken branches, saturating

Behaviour:
- Reset (asynchronous, rst_n low): state IDLE, all registers cleared, every output 0 except id_ready=1 once state is IDLE.
- States:
  - IDLE: id_ready=1.
    - On id_valid with a branch opcode (0x04 beq, 0x05 bne, 0x01 bgez/bltz, 0x07 bgtz, 0x06 blez): capture opcode, rt, pc, imm and operands; go to EVAL.
    - Non-branch opcodes are accepted and dropped; state stays IDLE.
  - EVAL (one cycle): id_ready=0.
    - Assert resolved_valid=1 and resolved_taken combinationally from the captured data.
    - branch_cnt increments; taken_cnt increments if taken.
    - Taken: go to REDIRECT, registering redirect_target. Not taken: go to IDLE.
  - REDIRECT: id_ready=0; redirect_valid=1 and redirect_target are held stable until the handshake.
    - On redirect_ready: flush_out=1 for that cycle; go to IDLE.
- Conditions, all signed 32-bit compares on rs (and rt where applicable):
  - beq: rs==rt. bne: rs!=rt.
  - 0x01 with rt=5'd1 (bgez): rs>=0. 0x01 with rt=5'd0 (bltz): rs<0. Any other rt under 0x01 is resolved not-taken.
  - bgtz: rs>0. blez: rs<=0.
- Target: pc + 4 + (sign_extend(imm) << 2), modulo 2^ADDR_W; wrap-around is silent.
- Latency: accept in cycle N → resolved_valid in N+1 → redirect_valid from N+2.
- flush_in:
  - In EVAL: suppresses resolved_valid and both counter increments; go to IDLE.
  - In REDIRECT: drops redirect_valid with no flush_out; go to IDLE.
  - Coincident with redirect_ready: flush_in wins and there is no flush_out.
  - In IDLE with id_valid: the instruction is not captured.
- Counters: each stops at 2^CNT_W-1 and never wraps; cleared only by reset.
- Reset asserted mid-REDIRECT: redirect_valid drops immediately (asynchronous); no flush_out.

Decomposition:
- branch_pkg holds:
  - Opcode constants OP_BEQ, OP_BNE, OP_REGIMM, OP_BGTZ, OP_BLEZ.
  - RT_BLTZ and RT_BGEZ codes.
  - State enum br_state_t {IDLE, EVAL, REDIRECT}.
- One combinational sub-module, branch_cond_eval, takes opcode, rt, rs_val and rt_val and returns taken.
- Target computation, FSM and counters stay in the top module.

Test Plan:
- beq, pc=0x0000_1000, imm=0x0004, rs=rt=5: resolved_valid and taken at N+1; redirect_valid and target 0x0000_1014 at N+2; redirect_ready held low 3 cycles keeps target stable; on ready, flush_out pulses once.
- bne, rs=rt=7: resolved_taken=0; no redirect; id_ready back to 1 at N+2; branch_cnt=1, taken_cnt=0.
- bltz rs=0xFFFF_FFFF taken; bgez rs=0 taken; bgtz rs=0 not taken; blez rs=0x8000_0000 taken; opcode 0x01 with rt=5'd16 not taken.
- pc=0x0000_0010, imm=0xFFF8: target 0xFFFF_FFF4 (negative offset); pc=0xFFFF_FFFC, imm=0x0001: target 0x0000_0004 (wrap).
- flush_in asserted in REDIRECT together with redirect_ready: no flush_out, state IDLE next cycle. flush_in in EVAL: counters unchanged.
- CNT_W=2 with 5 taken branches: both counters stick at 3. rst_n low mid-REDIRECT: all outputs 0 without waiting for a clock edge.
